// File: rtl/mlp_neuron_sequencer.sv
// Sequences the MMU address map to evaluate N_OUT fully connected neurons over N_IN
// inputs, one MMU read per cycle, and streams each ReLU-saturated result out on valid/ready.
module mlp_neuron_sequencer #(
    parameter int N_IN  = 6,
    parameter int N_OUT = 3,
    parameter int ACC_W = 40
) (
    input  logic        i_clk,
    input  logic        i_rst,          // active-low, asynchronous
    input  logic        i_start,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_mem_addr,
    output logic        o_mem_we,
    input  logic [15:0] i_mem_rdata,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [15:0] o_out_data,
    output logic [7:0]  o_out_idx
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH_B, S_LOAD_B, S_FETCH_D, S_FETCH_W, S_MAC, S_OUT, S_FIN
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic signed [ACC_W-1:0]  r_acc;
    logic [15:0]              r_x_reg;
    logic [15:0]              r_mem_addr;
    logic [7:0]               r_o_cnt;
    logic [7:0]               r_i_cnt;
    logic                     w_i_last;
    logic                     w_o_last;
    logic                     w_accept;
    logic signed [31:0]       w_prod;
    logic [15:0]              w_mem_addr;
    logic [15:0]              w_out_data;

    assign w_i_last = (r_i_cnt == 8'(N_IN - 1));
    assign w_o_last = (r_o_cnt == 8'(N_OUT - 1));
    assign w_accept = (r_state == S_OUT) && i_out_ready;
    assign w_prod   = $signed(r_x_reg) * $signed(i_mem_rdata);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (i_start) w_state_next = S_FETCH_B;
            S_FETCH_B: w_state_next = S_LOAD_B;
            S_LOAD_B:  w_state_next = S_FETCH_D;
            S_FETCH_D: w_state_next = S_FETCH_W;
            S_FETCH_W: w_state_next = S_MAC;
            S_MAC:     w_state_next = w_i_last ? S_OUT : S_FETCH_D;
            S_OUT:     if (w_accept) w_state_next = w_o_last ? S_FIN : S_FETCH_B;
            S_FIN:     w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // The MMU samples the address on the edge that leaves a FETCH state, so the
    // address is decoded from the current state and held in the register otherwise.
    always_comb begin
        o_busy      = (r_state != S_IDLE);
        o_done      = (r_state == S_FIN);
        o_out_valid = (r_state == S_OUT);
        o_mem_we    = 1'b0;
        w_mem_addr  = r_mem_addr;
        case (r_state)
            S_FETCH_B: w_mem_addr = 16'h0200 + 16'(r_o_cnt);
            S_FETCH_D: w_mem_addr = 16'(r_i_cnt);
            S_FETCH_W: w_mem_addr = 16'h0100 + 16'(r_o_cnt) * 16'(N_IN) + 16'(r_i_cnt);
            default:   ;
        endcase
    end

    assign o_mem_addr = w_mem_addr;

    always_comb begin
        if (r_acc[ACC_W-1])         w_out_data = 16'h0000;
        else if (|r_acc[ACC_W-2:15]) w_out_data = 16'h7FFF;
        else                        w_out_data = r_acc[15:0];
    end

    assign o_out_data = w_out_data;
    assign o_out_idx  = r_o_cnt;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_acc      <= '0;
            r_x_reg    <= '0;
            r_o_cnt    <= '0;
            r_i_cnt    <= '0;
            r_mem_addr <= '0;
        end else begin
            r_mem_addr <= w_mem_addr;
            case (r_state)
                S_IDLE: if (i_start) r_o_cnt <= '0;
                S_LOAD_B: begin
                    r_acc   <= {{(ACC_W-16){i_mem_rdata[15]}}, i_mem_rdata};
                    r_i_cnt <= '0;
                end
                S_FETCH_W: r_x_reg <= i_mem_rdata;
                S_MAC: begin
                    r_acc <= r_acc + {{(ACC_W-32){w_prod[31]}}, w_prod};
                    if (!w_i_last) r_i_cnt <= r_i_cnt + 8'd1;
                end
                S_OUT: if (w_accept && !w_o_last) r_o_cnt <= r_o_cnt + 8'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mlp_neuron_sequencer.sv
// Bench for mlp_neuron_sequencer: MMU model with registered read, constant-vector table,
// hand-built stall/abort sequences and randomized runs checked against an arithmetic model.
module tb_mlp_neuron_sequencer;
    localparam int N_IN  = 6;
    localparam int N_OUT = 3;
    localparam int N_W   = N_IN * N_OUT;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done, mem_we, out_valid, out_ready;
    logic [15:0] mem_addr, mem_rdata, out_data;
    logic [7:0]  out_idx;

    mlp_neuron_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .ACC_W(40)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .o_busy(busy), .o_done(done),
        .o_mem_addr(mem_addr), .o_mem_we(mem_we), .i_mem_rdata(mem_rdata),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_data(out_data), .o_out_idx(out_idx)
    );

    always #5 clk = ~clk;

    logic [15:0] x_mem [N_IN];
    logic [15:0] w_mem [N_W];
    logic [15:0] b_mem [N_OUT];
    logic [15:0] exp_y [N_OUT];
    logic [15:0] exp_addr [$];
    logic [15:0] last_addr = 16'h0000;
    bit          we_bad = 1'b0;
    int          chk_cnt = 0;
    int          pass_cnt = 0;

    function automatic logic [15:0] mmu_read(input logic [15:0] a);
        if (a < 16'(N_IN))                              return x_mem[a];
        if (a >= 16'h0100 && a < 16'h0100 + 16'(N_W))   return w_mem[a - 16'h0100];
        if (a >= 16'h0200 && a < 16'h0200 + 16'(N_OUT)) return b_mem[a - 16'h0200];
        return 16'hDEAD;
    endfunction

    always @(posedge clk) mem_rdata <= mmu_read(mem_addr);

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        chk_cnt++;
        if (got === want) pass_cnt++;
        else $display("FAIL %s: got %0h want %0h", nm, got, want);
    endtask

    // Address monitor: every new address seen while busy must be the next one of the map walk.
    always @(negedge clk) begin
        if (mem_we !== 1'b0) we_bad = 1'b1;
        if (busy === 1'b1 && mem_addr !== last_addr) begin
            if (exp_addr.size() == 0) chk("mem_addr_extra", {16'h0, mem_addr}, 32'hFFFF_FFFF);
            else                      chk("mem_addr", {16'h0, mem_addr}, {16'h0, exp_addr.pop_front()});
        end
        last_addr = mem_addr;
    end

    function automatic void push_addrs();
        for (int o = 0; o < N_OUT; o++) begin
            exp_addr.push_back(16'h0200 + 16'(o));
            for (int i = 0; i < N_IN; i++) begin
                exp_addr.push_back(16'(i));
                exp_addr.push_back(16'h0100 + 16'(o * N_IN + i));
            end
        end
    endfunction

    function automatic logic [15:0] ref_y(input int o);
        longint acc;
        acc = longint'($signed(b_mem[o]));
        for (int i = 0; i < N_IN; i++)
            acc += longint'($signed(x_mem[i])) * longint'($signed(w_mem[o * N_IN + i]));
        if (acc < 0)     return 16'h0000;
        if (acc > 32767) return 16'h7FFF;
        return 16'(acc);
    endfunction

    function automatic void fill_uniform(input logic [15:0] xv, input logic [15:0] wv, input logic [15:0] bv);
        for (int i = 0; i < N_IN; i++)  x_mem[i] = xv;
        for (int k = 0; k < N_W; k++)   w_mem[k] = wv;
        for (int o = 0; o < N_OUT; o++) b_mem[o] = bv;
    endfunction

    function automatic void fill_distinct();
        for (int i = 0; i < N_IN; i++)  x_mem[i] = 16'(i + 1);
        for (int k = 0; k < N_W; k++)   w_mem[k] = 16'(k);
        for (int o = 0; o < N_OUT; o++) b_mem[o] = 16'(o);
        exp_y[0] = 16'd70; exp_y[1] = 16'd197; exp_y[2] = 16'd324;
    endfunction

    function automatic logic [15:0] rnd16();
        if ($urandom_range(0, 3) == 0) return 16'($urandom);
        return 16'($urandom_range(0, 400)) - 16'd200;
    endfunction

    task automatic run_seq(input string tag, input bit chk_lat, input int stall_o,
                           input int stall_n, input int pulse_at);
        int cyc, got, lat, extra_done;
        bit stalled, fin;
        logic [15:0] snap_d, snap_a;
        logic [7:0]  snap_i;
        cyc = 0; got = 0; lat = -1; extra_done = 0; stalled = 0; fin = 0;
        push_addrs();
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk); start = 1'b0; cyc = 1;
        while (!fin) begin
            if (cyc > 1000) begin
                chk({tag, "_timeout"}, cyc, 0);
                break;
            end
            start = (cyc == pulse_at);
            if (out_valid && lat < 0) lat = cyc;
            if (done) begin
                chk({tag, "_done_after_all"}, got, N_OUT);
                @(negedge clk); cyc++;
                chk({tag, "_busy_after_done"}, busy, 0);
                fin = 1;
            end else if (out_valid) begin
                if (got == stall_o && !stalled) begin
                    out_ready = 1'b0; stalled = 1;
                    snap_d = out_data; snap_i = out_idx; snap_a = mem_addr;
                    repeat (stall_n) begin
                        @(negedge clk); cyc++;
                        chk({tag, "_stall_valid"}, out_valid, 1);
                        chk({tag, "_stall_data"}, out_data, snap_d);
                        chk({tag, "_stall_idx"}, out_idx, snap_i);
                        chk({tag, "_stall_addr"}, mem_addr, snap_a);
                    end
                    out_ready = 1'b1;
                end
                chk({tag, "_data"}, out_data, exp_y[got]);
                chk({tag, "_idx"}, out_idx, got);
                got++;
                @(negedge clk); cyc++;
            end else begin
                @(negedge clk); cyc++;
            end
        end
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) extra_done++;
        end
        chk({tag, "_done_once"}, extra_done, 0);
        chk({tag, "_idle_busy"}, busy, 0);
        if (chk_lat) chk({tag, "_latency"}, lat, 21);
        chk({tag, "_addr_left"}, exp_addr.size(), 0);
        chk({tag, "_mem_we"}, we_bad, 0);
    endtask

    typedef struct {
        string       name;
        logic [15:0] x, w, b;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl [6];

    initial begin
        int cyc;
        bit saw_done;
        tbl[0] = '{"all_pos",    16'h0001, 16'h0002, 16'h0003, 16'd15};
        tbl[1] = '{"relu_neg",   16'h0001, 16'hFFFF, 16'h0002, 16'h0000};
        tbl[2] = '{"relu_bias",  16'h0000, 16'h0005, 16'hFFFB, 16'h0000};
        tbl[3] = '{"sat_pos",    16'h7FFF, 16'h7FFF, 16'h0000, 16'h7FFF};
        tbl[4] = '{"sat_negneg", 16'h8000, 16'h8000, 16'h0000, 16'h7FFF};
        tbl[5] = '{"small_mix",  16'h0003, 16'hFFFE, 16'd40,   16'd4};

        rst = 1'b0; start = 1'b0; out_ready = 1'b0;
        fill_uniform(16'h0, 16'h0, 16'h0);
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_we", mem_we, 0);
        rst = 1'b1;
        @(negedge clk);

        foreach (tbl[k]) begin
            fill_uniform(tbl[k].x, tbl[k].w, tbl[k].b);
            for (int o = 0; o < N_OUT; o++) exp_y[o] = tbl[k].exp;
            run_seq(tbl[k].name, k == 0, -1, 0, -1);
        end

        fill_distinct();
        run_seq("distinct", 1'b1, -1, 0, -1);

        // Back-pressure at neuron 1 plus a start pulse during neuron 0's MAC phase.
        fill_distinct();
        run_seq("stall", 1'b1, 1, 10, 10);

        // Abort: reset asserted during the first MAC of neuron 1.
        fill_distinct();
        push_addrs();
        out_ready = 1'b1; start = 1'b1; saw_done = 0;
        @(negedge clk); start = 1'b0; cyc = 1;
        while (cyc < 26) begin
            @(negedge clk); cyc++;
            if (done) saw_done = 1;
        end
        chk("abort_pre_busy", busy, 1);
        chk("abort_pre_idx", out_idx, 1);
        #2 rst = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_data", out_data, 0);
        chk("abort_idx", out_idx, 0);
        chk("abort_addr", mem_addr, 0);
        chk("abort_we", mem_we, 0);
        exp_addr.delete();
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        chk("abort_no_done", saw_done, 0);
        chk("abort_stays_idle", busy, 0);
        run_seq("recover", 1'b1, -1, 0, -1);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N_IN; i++)  x_mem[i] = rnd16();
            for (int k = 0; k < N_W; k++)   w_mem[k] = rnd16();
            for (int o = 0; o < N_OUT; o++) b_mem[o] = rnd16();
            for (int o = 0; o < N_OUT; o++) exp_y[o] = ref_y(o);
            run_seq($sformatf("rand%0d", r), 1'b1,
                    (r % 2 == 1) ? int'($urandom_range(0, N_OUT - 1)) : -1,
                    int'($urandom_range(1, 6)), -1);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
